pin_entry_ctrl: RTL and testbench

Sequences keypad entry for the PIN lock.
- Assembles four BCD digits into a 16-bit PIN and issues a one-cycle pin_valid strobe to the PIN verifier.
- Samples the verifier status, counts consecutive failures and enforces a timed lockout.
- Owns the stored-PIN register and rewrites it during adjustment mode.
- Sits between the keypad decoder and the verifier, on the 500 Hz clock domain.

---
 rtl/pin_pkg.sv | 24 ++
 rtl/pin_digit_accum.sv | 50 +++++
 rtl/pin_entry_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// rtl/pin_pkg.sv - shared state encoding, verifier status codes and PIN geometry
package pin_pkg;

  localparam int PIN_W  = 16;
  localparam int DIGITS = 4;

  localparam logic [1:0] STATUS_LOCKED = 2'd0;
  localparam logic [1:0] STATUS_OPEN   = 2'd1;
  localparam logic [1:0] STATUS_ADJUST = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_PROGRAM,
    ST_LOCKOUT
  } state_e;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_digit_accum.sv
// rtl/pin_digit_accum.sv - BCD digit shift register with count, clear and completion pulse
module pin_digit_accum
  import pin_pkg::*;
(
  input  logic             clk_500Hz,
  input  logic             rst_n,
  input  logic             accept_en,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             clear,
  output logic [PIN_W-1:0] user_pin,
  output logic [2:0]       digit_count,
  output logic             accepted,
  output logic             done
);

  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  logic [PIN_W-1:0] pin_q, pin_d;
  logic [2:0]       count_q, count_d;

  always_comb begin
    // clear always beats a simultaneous digit
    accepted = accept_en && digit_valid && is_bcd(digit) && !clear;
    done     = accepted && (count_q == LAST);
    pin_d    = pin_q;
    count_d  = count_q;
    if (clear) begin
      pin_d   = '0;
      count_d = '0;
    end else if (accepted) begin
      pin_d   = {pin_q[PIN_W-5:0], digit};
      count_d = done ? 3'd0 : count_q + 3'd1;
    end
  end

  always_ff @(posedge clk_500Hz) begin
    if (!rst_n) begin
      pin_q   <= '0;
      count_q <= '0;
    end else begin
      pin_q   <= pin_d;
      count_q <= count_d;
    end
  end

  assign user_pin    = pin_q;
  assign digit_count = count_q;

endmodule

// File: rtl/pin_entry_ctrl.sv
// rtl/pin_entry_ctrl.sv - keypad PIN sequencer with fail counting, lockout and stored-PIN reprogramming
// Optional inter-digit inactivity timeout enabled by defining ENTRY_TIMEOUT_EN.
module pin_entry_ctrl
  import pin_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 5000,
  parameter int          VERIFY_WAIT    = 2,
  parameter int          ENTRY_TIMEOUT  = 2500
) (
  input  logic        clk_500Hz,
  input  logic        rst_n,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear,
  input  logic [1:0]  status_in,
  output logic [15:0] user_pin,
  output logic        pin_valid,
  output logic [15:0] stored_pin,
  output logic [2:0]  digit_count,
  output logic [2:0]  fail_count,
  output logic        lockout
);

  // one width covers both the lockout and inactivity timers
  localparam int TMR_W = $clog2((LOCKOUT_CYCLES > ENTRY_TIMEOUT ? LOCKOUT_CYCLES : ENTRY_TIMEOUT) + 1);
  localparam logic [2:0] MAX_F = 3'(MAX_FAILS);

  state_e           state_q, state_d;
  logic [2:0]       fail_q, fail_d;
  logic [PIN_W-1:0] stored_q, stored_d;
  logic             pin_valid_q, pin_valid_d;
  logic [7:0]       wait_q, wait_d;
  logic [TMR_W-1:0] lock_q, lock_d;
`ifdef ENTRY_TIMEOUT_EN
  logic [TMR_W-1:0] idle_q, idle_d;
`endif

  logic             accept_en, acc_clear, acc_accepted, acc_done, timeout;
  logic [PIN_W-1:0] acc_pin;
  logic [2:0]       acc_count;

  pin_digit_accum u_accum (
    .clk_500Hz  (clk_500Hz),
    .rst_n      (rst_n),
    .accept_en  (accept_en),
    .digit_valid(digit_valid),
    .digit      (digit),
    .clear      (acc_clear),
    .user_pin   (acc_pin),
    .digit_count(acc_count),
    .accepted   (acc_accepted),
    .done       (acc_done)
  );

  always_ff @(posedge clk_500Hz) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fail_q      <= '0;
      stored_q    <= DEFAULT_PIN;
      pin_valid_q <= 1'b0;
      wait_q      <= '0;
      lock_q      <= '0;
`ifdef ENTRY_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fail_q      <= fail_d;
      stored_q    <= stored_d;
      pin_valid_q <= pin_valid_d;
      wait_q      <= wait_d;
      lock_q      <= lock_d;
`ifdef ENTRY_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    fail_d      = fail_q;
    stored_d    = stored_q;
    pin_valid_d = 1'b0;
    wait_d      = wait_q;
    lock_d      = lock_q;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (acc_done) begin
          pin_valid_d = 1'b1;
          wait_d      = 8'(VERIFY_WAIT);
          state_d     = ST_CHECK;
        end else if (acc_clear) begin
          state_d = ST_IDLE;
        end else if (acc_accepted) begin
          state_d = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        if (wait_q != 8'd0) begin
          wait_d = wait_q - 8'd1;
        end else if (status_in == STATUS_OPEN) begin
          fail_d  = '0;
          state_d = ST_OPEN;
        end else begin
          fail_d = (fail_q < MAX_F) ? fail_q + 3'd1 : fail_q;
          if (fail_d == MAX_F) begin
            lock_d  = TMR_W'(LOCKOUT_CYCLES - 1);
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (status_in == STATUS_ADJUST) state_d = ST_PROGRAM;
        else if (status_in == STATUS_LOCKED) state_d = ST_IDLE;
      end
      ST_PROGRAM: begin
        if (status_in == STATUS_LOCKED) begin
          state_d = ST_IDLE;
        end else if (acc_done) begin
          stored_d    = {acc_pin[PIN_W-5:0], digit};
          pin_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (lock_q == '0) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ENTRY_TIMEOUT_EN
    idle_d = '0;
    if ((state_q == ST_ENTRY || state_q == ST_PROGRAM) && !acc_accepted && !acc_clear)
      idle_d = idle_q + 1'b1;
`endif
  end

  always_comb begin
    accept_en = (state_q == ST_IDLE) || (state_q == ST_ENTRY) ||
                (state_q == ST_PROGRAM && status_in != STATUS_LOCKED);
`ifdef ENTRY_TIMEOUT_EN
    // a digit arriving on the expiry cycle still counts as activity
    timeout = (state_q == ST_ENTRY || state_q == ST_PROGRAM) &&
              (idle_q == TMR_W'(ENTRY_TIMEOUT - 1)) && !(digit_valid && is_bcd(digit));
`else
    timeout = 1'b0;
`endif
    acc_clear = (clear && (state_q == ST_IDLE || state_q == ST_ENTRY || state_q == ST_PROGRAM)) ||
                (state_q == ST_OPEN && status_in == STATUS_ADJUST) ||
                (state_q == ST_PROGRAM && status_in == STATUS_LOCKED) ||
                timeout;
    lockout     = (state_q == ST_LOCKOUT);
    pin_valid   = pin_valid_q;
    stored_pin  = stored_q;
    fail_count  = fail_q;
    user_pin    = acc_pin;
    digit_count = acc_count;
  end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb/tb_pin_entry_ctrl.sv - scoreboard bench for pin_entry_ctrl
module tb_pin_entry_ctrl;

  logic        clk_500Hz = 1'b0;
  logic        rst_n = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        clear = 1'b0;
  logic [1:0]  status_in = 2'd0;
  logic [15:0] user_pin, stored_pin;
  logic        pin_valid, lockout;
  logic [2:0]  digit_count, fail_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] pin;
    logic [15:0] stored;
  } strobe_t;

  strobe_t exp_q[$];
  strobe_t mon_e;
  logic    prev_pv = 1'b0;

  pin_entry_ctrl dut (
    .clk_500Hz  (clk_500Hz),
    .rst_n      (rst_n),
    .digit_valid(digit_valid),
    .digit      (digit),
    .clear      (clear),
    .status_in  (status_in),
    .user_pin   (user_pin),
    .pin_valid  (pin_valid),
    .stored_pin (stored_pin),
    .digit_count(digit_count),
    .fail_count (fail_count),
    .lockout    (lockout)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every pin_valid strobe must match the next queued expectation
  always @(negedge clk_500Hz) begin
    if (rst_n && pin_valid) begin
      chk("pin_valid_not_back_to_back", 32'(prev_pv), 32'd0);
      chk("strobe_was_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("strobe_user_pin", 32'(user_pin), 32'(mon_e.pin));
        chk("strobe_stored_pin", 32'(stored_pin), 32'(mon_e.stored));
      end
    end
    prev_pv = pin_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_500Hz);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    tick(1);
    digit_valid = 1'b0;
  endtask

  task automatic entry(input logic [15:0] pin, input logic [15:0] stored, input int settle);
    exp_q.push_back({pin, stored});
    for (int i = 3; i >= 0; i--) press(pin[i*4 +: 4]);
    tick(settle);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int w;
    tick(3);
    rst_n = 1'b1;
    chk("reset_user_pin", 32'(user_pin), 32'h0);
    chk("reset_pin_valid", 32'(pin_valid), 32'd0);
    chk("reset_digit_count", 32'(digit_count), 32'd0);
    chk("reset_fail_count", 32'(fail_count), 32'd0);
    chk("reset_lockout", 32'(lockout), 32'd0);
    chk("reset_stored_pin", 32'(stored_pin), 32'h1234);

    // correct entry reaches OPEN
    status_in = 2'd1;
    entry(16'h1234, 16'h1234, 4);
    chk("open_fail_count", 32'(fail_count), 32'd0);
    chk("open_lockout", 32'(lockout), 32'd0);
    press(4'd7);
    chk("open_ignores_digit", 32'(digit_count), 32'd0);

    // adjust mode rewrites stored PIN
    status_in = 2'd2;
    tick(2);
    entry(16'h5678, 16'h5678, 1);
    chk("program_stored_pin", 32'(stored_pin), 32'h5678);
    chk("program_digit_count", 32'(digit_count), 32'd0);
    status_in = 2'd1;
    entry(16'h5678, 16'h5678, 4);
    chk("new_pin_open_fail_count", 32'(fail_count), 32'd0);
    status_in = 2'd0;
    tick(2);

    // three wrong entries then lockout
    entry(16'h9999, 16'h5678, 4);
    chk("fail_count_1", 32'(fail_count), 32'd1);
    chk("no_lockout_after_1", 32'(lockout), 32'd0);
    entry(16'h9999, 16'h5678, 4);
    chk("fail_count_2", 32'(fail_count), 32'd2);
    entry(16'h9999, 16'h5678, 0);
    w = 0;
    while (!lockout && w < 10) begin
      @(negedge clk_500Hz);
      w++;
    end
    chk("lockout_entered", 32'(lockout), 32'd1);
    chk("fail_count_3", 32'(fail_count), 32'd3);
    cnt = 0;
    while (lockout && cnt < 6000) begin
      cnt++;
      digit_valid = (cnt >= 10 && cnt < 14);
      digit       = 4'd1;
      clear       = (cnt == 20);
      @(negedge clk_500Hz);
    end
    digit_valid = 1'b0;
    clear       = 1'b0;
    chk("lockout_cycles", 32'(cnt), 32'd5000);
    chk("fail_count_after_lockout", 32'(fail_count), 32'd0);
    chk("lockout_digits_ignored", 32'(digit_count), 32'd0);
    chk("lockout_user_pin_held", 32'(user_pin), 32'h9999);
    tick(1);

    // clear beats a simultaneous digit
    press(4'd1);
    press(4'd2);
    chk("two_digits_count", 32'(digit_count), 32'd2);
    chk("two_digits_pin", 32'(user_pin), 32'h9912);
    clear       = 1'b1;
    digit_valid = 1'b1;
    digit       = 4'd3;
    tick(1);
    clear       = 1'b0;
    digit_valid = 1'b0;
    chk("clear_count", 32'(digit_count), 32'd0);
    chk("clear_pin", 32'(user_pin), 32'h0);

    // non-BCD digit ignored
    press(4'd1);
    press(4'hA);
    chk("non_bcd_count", 32'(digit_count), 32'd1);
    chk("non_bcd_pin", 32'(user_pin), 32'h0001);
    press(4'd2);
    chk("after_non_bcd_pin", 32'(user_pin), 32'h0012);

    // inactivity boundary
    tick(2499);
    chk("idle_2499_count", 32'(digit_count), 32'd2);
    tick(1);
`ifdef ENTRY_TIMEOUT_EN
    chk("idle_2500_count", 32'(digit_count), 32'd0);
    chk("idle_2500_pin", 32'(user_pin), 32'h0);
`else
    chk("idle_2500_count", 32'(digit_count), 32'd2);
    chk("idle_2500_pin", 32'(user_pin), 32'h0012);
`endif
    clear = 1'b1;
    tick(1);
    clear = 1'b0;

    // reset in the middle of lockout
    status_in = 2'd0;
    entry(16'h9999, 16'h5678, 4);
    entry(16'h9999, 16'h5678, 4);
    entry(16'h9999, 16'h5678, 100);
    chk("second_lockout_active", 32'(lockout), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("midlock_reset_lockout", 32'(lockout), 32'd0);
    chk("midlock_reset_stored", 32'(stored_pin), 32'h1234);
    chk("midlock_reset_fail", 32'(fail_count), 32'd0);
    chk("midlock_reset_count", 32'(digit_count), 32'd0);
    rst_n = 1'b1;
    tick(3);

    chk("strobes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
